// File: rtl/hp_tracker_if.sv
// Event strobes into and HP/status outputs out of the player HP tracker.
// Strobes are single-cycle pulses; there is no handshake or backpressure.
interface hp_tracker_if;
    logic        i_frame_tick;
    logic        i_start;
    logic        i_hit;
    logic [15:0] i_dmg;
    logic        i_heal;
    logic [15:0] i_heal_amt;
    logic [15:0] o_total_hp;
    logic [15:0] o_remain_hp;
    logic [15:0] o_actual_hp;
    logic        o_invincible;
    logic        o_dead;

    modport master (
        output i_frame_tick, i_start, i_hit, i_dmg, i_heal, i_heal_amt,
        input  o_total_hp, o_remain_hp, o_actual_hp, o_invincible, o_dead
    );

    modport slave (
        input  i_frame_tick, i_start, i_hit, i_dmg, i_heal, i_heal_amt,
        output o_total_hp, o_remain_hp, o_actual_hp, o_invincible, o_dead
    );
endinterface

// File: rtl/hp_tracker.sv
// Player HP keeper: damage/heal, invincibility frames, death, draining display HP.
// All outputs registered, one cycle after the strobe; events are never stalled.
module hp_tracker #(
    parameter int MAX_HP       = 20,
    parameter int IFRAME_TICKS = 60,
    parameter int DRAIN_TICKS  = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    hp_tracker_if.slave  bus
);
    localparam logic [15:0] MAXV = 16'(MAX_HP);
    localparam int IW = $clog2(IFRAME_TICKS + 1);
    localparam int DW = (DRAIN_TICKS > 1) ? $clog2(DRAIN_TICKS) : 1;

    typedef enum logic [1:0] {IDLE, ALIVE, INVULN, DEAD} state_t;

    state_t        r_state,   w_state_nxt;
    logic [15:0]   r_actual,  w_actual_nxt;
    logic [15:0]   r_display, w_display_nxt;
    logic [IW-1:0] r_iframe,  w_iframe_nxt;
    logic [DW-1:0] r_drain,   w_drain_nxt;

    logic [15:0] w_hit_res;
    logic [16:0] w_heal_sum;
    logic [15:0] w_heal_res;

    // Saturating subtract and clamped 17-bit add so neither can wrap.
    assign w_hit_res  = (bus.i_dmg >= r_actual) ? 16'd0 : (r_actual - bus.i_dmg);
    assign w_heal_sum = {1'b0, r_actual} + {1'b0, bus.i_heal_amt};
    assign w_heal_res = (w_heal_sum > {1'b0, MAXV}) ? MAXV : w_heal_sum[15:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_actual  <= MAXV;
            r_display <= MAXV;
            r_iframe  <= '0;
            r_drain   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_actual  <= w_actual_nxt;
            r_display <= w_display_nxt;
            r_iframe  <= w_iframe_nxt;
            r_drain   <= w_drain_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_actual_nxt = r_actual;
        w_iframe_nxt = r_iframe;

        case (r_state)
            ALIVE: begin
                if (bus.i_hit && (bus.i_dmg != 16'd0)) begin
                    w_actual_nxt = w_hit_res;
                    if (w_hit_res == 16'd0) begin
                        w_state_nxt = DEAD;
                    end else begin
                        w_state_nxt  = INVULN;
                        w_iframe_nxt = IW'(IFRAME_TICKS);
                    end
                end else if (bus.i_heal) begin
                    w_actual_nxt = w_heal_res;
                end
            end
            INVULN: begin
                if (bus.i_heal) begin
                    w_actual_nxt = w_heal_res;
                end
                if (bus.i_frame_tick) begin
                    if (r_iframe == IW'(1)) begin
                        w_state_nxt  = ALIVE;
                        w_iframe_nxt = '0;
                    end else begin
                        w_iframe_nxt = r_iframe - IW'(1);
                    end
                end
            end
            default: ;
        endcase

        if (bus.i_start) begin
            w_state_nxt  = ALIVE;
            w_actual_nxt = MAXV;
            w_iframe_nxt = '0;
        end
    end

    // Display rises instantly to actual but drains one point per DRAIN_TICKS frames.
    always_comb begin
        w_display_nxt = r_display;
        w_drain_nxt   = r_drain;

        if (bus.i_start) begin
            w_display_nxt = MAXV;
            w_drain_nxt   = '0;
        end else if (r_actual > r_display) begin
            w_display_nxt = r_actual;
            w_drain_nxt   = '0;
        end else if (r_actual < r_display) begin
            if (bus.i_frame_tick) begin
                if (r_drain == DW'(DRAIN_TICKS - 1)) begin
                    w_display_nxt = r_display - 16'd1;
                    w_drain_nxt   = '0;
                end else begin
                    w_drain_nxt = r_drain + DW'(1);
                end
            end
        end else begin
            w_drain_nxt = '0;
        end
    end

    assign bus.o_total_hp   = MAXV;
    assign bus.o_remain_hp  = r_display;
    assign bus.o_actual_hp  = r_actual;
    assign bus.o_invincible = (r_state == INVULN);
    assign bus.o_dead       = (r_state == DEAD);
endmodule

// File: tb/tb_hp_tracker.sv
// Directed bench for hp_tracker with hand-computed expected HP, display and flags.
module tb_hp_tracker;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    hp_tracker_if bus();

    hp_tracker #(
        .MAX_HP      (20),
        .IFRAME_TICKS(60),
        .DRAIN_TICKS (2)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus.slave)
    );

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One clock with the given strobes held across the edge; returns 1 ns after it.
    task automatic cyc(input logic tk, input logic st, input logic ht, input logic [15:0] dmg,
                       input logic hl, input logic [15:0] amt);
        bus.i_frame_tick = tk;
        bus.i_start      = st;
        bus.i_hit        = ht;
        bus.i_dmg        = dmg;
        bus.i_heal       = hl;
        bus.i_heal_amt   = amt;
        @(posedge clk);
        #1;
        bus.i_frame_tick = 1'b0;
        bus.i_start      = 1'b0;
        bus.i_hit        = 1'b0;
        bus.i_dmg        = 16'd0;
        bus.i_heal       = 1'b0;
        bus.i_heal_amt   = 16'd0;
    endtask

    initial begin
        int exp_d;
        bus.i_frame_tick = 1'b0;
        bus.i_start      = 1'b0;
        bus.i_hit        = 1'b0;
        bus.i_dmg        = 16'd0;
        bus.i_heal       = 1'b0;
        bus.i_heal_amt   = 16'd0;

        // T1: reset values, IDLE ignores hits, start enters ALIVE
        #12;
        check_val("rst_actual", bus.o_actual_hp, 16'd20);
        check_val("rst_disp",   bus.o_remain_hp, 16'd20);
        check_val("rst_total",  bus.o_total_hp,  16'd20);
        check_val("rst_inv",    16'(bus.o_invincible), 16'd0);
        check_val("rst_dead",   16'(bus.o_dead),       16'd0);
        rst_n = 1'b1;
        cyc(0, 0, 1, 16'd5, 0, 16'd0);
        check_val("idle_hit", bus.o_actual_hp, 16'd20);
        cyc(0, 1, 0, 16'd0, 0, 16'd0);
        check_val("t1_actual", bus.o_actual_hp, 16'd20);
        check_val("t1_disp",   bus.o_remain_hp, 16'd20);
        check_val("t1_inv",    16'(bus.o_invincible), 16'd0);
        check_val("t1_dead",   16'(bus.o_dead),       16'd0);

        // T2: hit 5, display drain, ignored hit during iframes, iframe expiry
        cyc(0, 0, 1, 16'd5, 0, 16'd0);
        check_val("t2_actual", bus.o_actual_hp, 16'd15);
        check_val("t2_inv",    16'(bus.o_invincible), 16'd1);
        check_val("t2_disp0",  bus.o_remain_hp, 16'd20);
        for (int k = 1; k <= 60; k++) begin
            cyc(1, 0, (k == 30), 16'd3, 0, 16'd0);
            exp_d = 20 - k / 2;
            if (exp_d < 15) exp_d = 15;
            if (k <= 12) check_val("t2_disp", bus.o_remain_hp, 16'(exp_d));
            if (k == 30) check_val("t2_ign_hit", bus.o_actual_hp, 16'd15);
            if (k == 59) check_val("t2_inv59", 16'(bus.o_invincible), 16'd1);
            if (k == 60) check_val("t2_inv60", 16'(bus.o_invincible), 16'd0);
        end

        // T3: bring actual to 4, overkill hit saturates, death and drain to 0
        cyc(0, 0, 1, 16'd11, 0, 16'd0);
        check_val("t3_actual4", bus.o_actual_hp, 16'd4);
        for (int k = 1; k <= 60; k++) cyc(1, 0, 0, 16'd0, 0, 16'd0);
        check_val("t3_inv_off", 16'(bus.o_invincible), 16'd0);
        check_val("t3_disp4",   bus.o_remain_hp, 16'd4);
        cyc(0, 0, 1, 16'd9, 0, 16'd0);
        check_val("t3_sat",   bus.o_actual_hp, 16'd0);
        check_val("t3_dead",  16'(bus.o_dead),       16'd1);
        check_val("t3_inv",   16'(bus.o_invincible), 16'd0);
        for (int k = 1; k <= 8; k++) begin
            cyc(1, 0, k[0], 16'd1, !k[0], 16'd5);
            check_val("t3_dead_act", bus.o_actual_hp, 16'd0);
            if (k == 7) check_val("t3_disp1", bus.o_remain_hp, 16'd1);
        end
        check_val("t3_disp0",  bus.o_remain_hp, 16'd0);
        check_val("t3_dead2",  16'(bus.o_dead), 16'd1);
        cyc(0, 1, 1, 16'd3, 0, 16'd0);
        check_val("t3_rs_act",  bus.o_actual_hp, 16'd20);
        check_val("t3_rs_disp", bus.o_remain_hp, 16'd20);
        check_val("t3_rs_dead", 16'(bus.o_dead), 16'd0);

        // T4: clamped heal with instant rise, zero-damage hit, hit beats heal
        cyc(0, 0, 1, 16'd5, 0, 16'd0);
        for (int k = 1; k <= 4; k++) cyc(1, 0, 0, 16'd0, 0, 16'd0);
        check_val("t4_disp18", bus.o_remain_hp, 16'd18);
        cyc(0, 0, 0, 16'd0, 1, 16'd10);
        check_val("t4_heal", bus.o_actual_hp, 16'd20);
        cyc(0, 0, 0, 16'd0, 0, 16'd0);
        check_val("t4_rise", bus.o_remain_hp, 16'd20);
        for (int k = 1; k <= 56; k++) begin
            cyc(1, 0, 0, 16'd0, 0, 16'd0);
            if (k == 55) check_val("t4_inv55", 16'(bus.o_invincible), 16'd1);
        end
        check_val("t4_inv_off", 16'(bus.o_invincible), 16'd0);
        cyc(0, 0, 1, 16'd0, 0, 16'd0);
        check_val("t4_zero_act", bus.o_actual_hp, 16'd20);
        check_val("t4_zero_inv", 16'(bus.o_invincible), 16'd0);
        cyc(0, 0, 1, 16'd2, 1, 16'd5);
        check_val("t4_hitwins", bus.o_actual_hp, 16'd18);
        check_val("t4_hw_inv",  16'(bus.o_invincible), 16'd1);
        cyc(0, 0, 1, 16'd7, 1, 16'd1);
        check_val("t4_inv_heal", bus.o_actual_hp, 16'd19);

        // T5: async reset mid-drain returns to IDLE with full HP
        cyc(0, 1, 0, 16'd0, 0, 16'd0);
        cyc(0, 0, 1, 16'd8, 0, 16'd0);
        for (int k = 1; k <= 6; k++) cyc(1, 0, 0, 16'd0, 0, 16'd0);
        check_val("t5_act12",  bus.o_actual_hp, 16'd12);
        check_val("t5_disp17", bus.o_remain_hp, 16'd17);
        rst_n = 1'b0;
        #2;
        check_val("t5_rst_act",  bus.o_actual_hp, 16'd20);
        check_val("t5_rst_disp", bus.o_remain_hp, 16'd20);
        check_val("t5_rst_inv",  16'(bus.o_invincible), 16'd0);
        check_val("t5_rst_dead", 16'(bus.o_dead),       16'd0);
        rst_n = 1'b1;
        cyc(0, 0, 1, 16'd5, 0, 16'd0);
        check_val("t5_idle_hit", bus.o_actual_hp, 16'd20);
        cyc(0, 1, 0, 16'd0, 0, 16'd0);
        cyc(0, 0, 1, 16'd5, 0, 16'd0);
        check_val("t5_alive_hit", bus.o_actual_hp, 16'd15);
        check_val("t5_total",     bus.o_total_hp,  16'd20);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
